// File: rtl/jk_driver_pkg.sv
// Shared types and constants for the JK flip-flop bank driver.
package jk_driver_pkg;

   // Per-bit request codes carried on req_op
   typedef enum logic [1:0] {
      OP_HOLD   = 2'b00,
      OP_CLEAR  = 2'b01,
      OP_SET    = 2'b10,
      OP_TOGGLE = 2'b11
   } op_t;

   // Controller sequencing: accept, drive the bank for one clock, then verify
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DRIVE = 2'b01,
      CHECK = 2'b10
   } drv_state_t;

   // Mismatch counter saturates here instead of wrapping
   localparam logic [7:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/jk_driver_if.sv
// Request channel between the register-control master and the driver.
interface jk_driver_if
   import jk_driver_pkg::*;
#(
   parameter int WIDTH = 8
);

   logic             req_valid;
   logic             req_ready;
   op_t              req_op;
   logic [WIDTH-1:0] req_mask;

   modport master (output req_valid, output req_op, output req_mask, input req_ready);
   modport slave  (input req_valid, input req_op, input req_mask, output req_ready);

endinterface

// File: rtl/jk_excite.sv
// Combinational JK excitation: turns an op and mask into j/k drive and the
// flop state the bank should hold once that drive has been clocked in.
module jk_excite
   import jk_driver_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_t              op,
   input  logic [WIDTH-1:0] mask,
   input  logic [WIDTH-1:0] shadow,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] expected
);

   // Map each op to its JK excitation; unmasked bits see j=k=0 and hold
   always_comb begin
      j        = '0;
      k        = '0;
      expected = shadow;
      case (op)
         OP_HOLD: begin
            expected = shadow;
         end
         OP_CLEAR: begin
            k        = mask;
            expected = shadow & ~mask;
         end
         OP_SET: begin
            j        = mask;
            expected = shadow | mask;
         end
         OP_TOGGLE: begin
            j        = mask;
            k        = mask;
            expected = shadow ^ mask;
         end
         default: begin
            expected = shadow;
         end
      endcase
   end

endmodule

// File: rtl/jk_driver.sv
// Command-side controller for a bank of external JK flip-flops: accepts
// per-bit requests, pulses j/k for exactly one clock, tracks the expected
// flop state and verifies the bank's q outputs after every update.
module jk_driver
   import jk_driver_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr_bar,
   jk_driver_if.slave       req,
   input  logic             resync,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] shadow,
   output logic             done,
   output logic             err,
   output logic [7:0]       err_count
);

   drv_state_t       state_q;
   drv_state_t       state_d;
   logic             accept;
   logic [WIDTH-1:0] exc_j;
   logic [WIDTH-1:0] exc_k;
   logic [WIDTH-1:0] exc_expected;

   jk_excite #(.WIDTH(WIDTH)) u_excite (
      .op       (req.req_op),
      .mask     (req.req_mask),
      .shadow   (shadow),
      .j        (exc_j),
      .k        (exc_k),
      .expected (exc_expected)
   );

   // State register; clr_bar abandons any in-flight op
   always_ff @(posedge clk or negedge clr_bar) begin
      if (!clr_bar) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state: one DRIVE cycle then one CHECK cycle per accepted request
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = DRIVE;
         DRIVE:   state_d = CHECK;
         CHECK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake: resync has priority over a new request while idle
   always_comb begin
      req.req_ready = (state_q == IDLE) && clr_bar && !resync;
      accept        = req.req_ready && req.req_valid;
   end

   // Drive lines, shadow copy, completion/error pulses and mismatch counter;
   // shadow clears with the bank since both share clr_bar
   always_ff @(posedge clk or negedge clr_bar) begin
      if (!clr_bar) begin
         j         <= '0;
         k         <= '0;
         shadow    <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_count <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (resync) begin
                  shadow <= q_fb;
               end else if (accept) begin
                  j      <= exc_j;
                  k      <= exc_k;
                  shadow <= exc_expected;
               end
            end
            DRIVE: begin
               j <= '0;
               k <= '0;
            end
            CHECK: begin
               done <= 1'b1;
               err  <= (q_fb != shadow);
               if ((q_fb != shadow) && (err_count != ERR_CNT_MAX))
                  err_count <= err_count + 8'd1;
            end
            default: begin
               j <= '0;
               k <= '0;
            end
         endcase
      end
   end

endmodule
